// File: rtl/vend_pkg.sv
// Shared types and constants for the soda-machine change dispenser.
package vend_pkg;

  // Dispenser sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_VEND_REL,
    S_NICK,
    S_NICK_REL,
    S_DIME,
    S_DIME_REL,
    S_FAULT
  } state_t;

  // Coin values in cents.
  localparam int NICKEL = 5;
  localparam int DIME   = 10;

  // A single command needs at most two coins of one kind.
  localparam int NEED_W = 2;
  typedef logic [NEED_W-1:0] need_t;

  // Cents represented by a pair of pending coin needs.
  function automatic int change_cents(need_t n, need_t d);
    return int'(n) * NICKEL + int'(d) * DIME;
  endfunction

  // True in states that wait on an actuator handshake.
  function automatic logic is_handshake(state_t s);
    return (s != S_IDLE) && (s != S_FAULT);
  endfunction

endpackage

// File: rtl/hs_wait_timer.sv
// Handshake wait timer: counts cycles spent waiting in one state and flags
// the cycle on which the count would reach TMO.
module hs_wait_timer #(
  parameter int TMO = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // The count only needs to hold 0..TMO-1; the TMO-th cycle is the expiry.
  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);

  logic [CW-1:0] cnt;

  // Wait counter: cleared on any state change, advanced while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == CW'(TMO - 1));

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: serialises vend / nickel / dime actuator handshakes for
// one captured command, tracks coin inventory and latches fault conditions.
//
// Handshake: each actuator uses four-phase req/ack. req rises on entry to the
// operate state and stays high until ack is sampled high; req is then low and
// the block waits for ack to be sampled low before moving on. Only one req is
// ever high at a time.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int INV_W     = 8,
  parameter int NICK_INIT = 20,
  parameter int DIME_INIT = 20,
  parameter int TMO       = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dis,
  input  logic             oN,
  input  logic             oD,
  input  logic             o2D,
  output logic             vend_req,
  input  logic             vend_ack,
  output logic             nick_req,
  input  logic             nick_ack,
  output logic             dime_req,
  input  logic             dime_ack,
  input  logic             refill,
  input  logic [INV_W-1:0] refill_n,
  input  logic [INV_W-1:0] refill_d,
  input  logic             clr_fault,
  output logic             busy,
  output logic             exact_change,
  output logic             fault,
  output logic             overrun,
  output logic             short_chg,
  output state_t           state_dbg,
  output logic [INV_W-1:0] nick_cnt,
  output logic [INV_W-1:0] dime_cnt
);

  state_t state, next_state;
  need_t  need_n, need_d;
  need_t  req_d, cap_n, cap_d;
  logic   cap_short;
  logic   expired;
  logic   capture;

  assign capture = (state == S_IDLE) && dis;

  hs_wait_timer #(.TMO(TMO)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (next_state != state),
    .en      (is_handshake(state)),
    .expired (expired)
  );

  // Clamp the requested coins to what the inventory can actually serve.
  always_comb begin
    req_d     = o2D ? 2'd2 : (oD ? 2'd1 : 2'd0);
    cap_n     = {1'b0, (oN && (nick_cnt != '0))};
    cap_d     = req_d;
    cap_short = oN && (nick_cnt == '0);
    if (INV_W'(req_d) > dime_cnt) begin
      cap_d     = dime_cnt[1:0];
      cap_short = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode; an ack wins over a same-cycle timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (dis) next_state = S_VEND;
      S_VEND:     if (vend_ack) next_state = S_VEND_REL;
                  else if (expired) next_state = S_FAULT;
      S_VEND_REL: if (!vend_ack) begin
                    if (need_n != '0)      next_state = S_NICK;
                    else if (need_d != '0) next_state = S_DIME;
                    else                   next_state = S_IDLE;
                  end else if (expired) next_state = S_FAULT;
      S_NICK:     if (nick_ack) next_state = S_NICK_REL;
                  else if (expired) next_state = S_FAULT;
      S_NICK_REL: if (!nick_ack) next_state = (need_d != '0) ? S_DIME : S_IDLE;
                  else if (expired) next_state = S_FAULT;
      S_DIME:     if (dime_ack) next_state = S_DIME_REL;
                  else if (expired) next_state = S_FAULT;
      S_DIME_REL: if (!dime_ack) next_state = (need_d != '0) ? S_DIME : S_IDLE;
                  else if (expired) next_state = S_FAULT;
      S_FAULT:    if (clr_fault) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Registered actuator requests and fault flag, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vend_req <= 1'b0;
      nick_req <= 1'b0;
      dime_req <= 1'b0;
      fault    <= 1'b0;
    end else begin
      vend_req <= (next_state == S_VEND);
      nick_req <= (next_state == S_NICK);
      dime_req <= (next_state == S_DIME);
      fault    <= (next_state == S_FAULT);
    end
  end

  // Pending coin needs: loaded at capture, consumed on each ejector ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      need_n <= '0;
      need_d <= '0;
    end else if (next_state == S_FAULT) begin
      need_n <= '0;
      need_d <= '0;
    end else if (capture) begin
      need_n <= cap_n;
      need_d <= cap_d;
    end else begin
      if ((state == S_NICK) && nick_ack) need_n <= need_n - 1'b1;
      if ((state == S_DIME) && dime_ack) need_d <= need_d - 1'b1;
    end
  end

  // Coin inventory: refill only in an idle cycle without a command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nick_cnt <= INV_W'(NICK_INIT);
      dime_cnt <= INV_W'(DIME_INIT);
    end else if ((state == S_IDLE) && !dis && refill) begin
      nick_cnt <= refill_n;
      dime_cnt <= refill_d;
    end else begin
      if ((state == S_NICK) && nick_ack) nick_cnt <= nick_cnt - 1'b1;
      if ((state == S_DIME) && dime_ack) dime_cnt <= dime_cnt - 1'b1;
    end
  end

  // Sticky flags: cleared on fault exit, set by late commands or clamping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      short_chg <= 1'b0;
    end else begin
      if ((state == S_FAULT) && clr_fault) begin
        overrun   <= 1'b0;
        short_chg <= 1'b0;
      end
      if (dis && (state != S_IDLE)) overrun <= 1'b1;
      if (capture && cap_short) short_chg <= 1'b1;
    end
  end

  assign busy         = (state != S_IDLE);
  assign exact_change = (nick_cnt == '0) || (dime_cnt < INV_W'(2));
  assign state_dbg    = state;

endmodule
